// File: rtl/div_pkg.sv
// Shared state encoding for the divider family.
// Exports div_state_e and the DIV_STATE_W width.
package div_pkg;

  localparam int DIV_STATE_W = 2;

  typedef enum logic [DIV_STATE_W-1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
// Ports: r/q current partial remainder/quotient, d divisor magnitude, r_nxt/q_nxt results.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH:0] sh;
  logic [WIDTH:0] trial;

  // The shifted remainder is below 2*d, so WIDTH+1 bits hold it
  // and bit WIDTH of the difference is the borrow.
  always_comb begin
    sh    = {r, q[WIDTH-1]};
    trial = sh - {1'b0, d};
    if (!trial[WIDTH]) begin
      r_nxt = trial[WIDTH-1:0];
      q_nxt = {q[WIDTH-2:0], 1'b1};
    end else begin
      r_nxt = sh[WIDTH-1:0];
      q_nxt = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle.
// Ports: clk, rst (async low), start/is_signed/dividend/divisor in; busy/valid/quot/rem/div_by_zero out.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_e       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_mag;
  logic             q_neg;
  logic             r_neg;

  logic             sgn_mode;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Constant-false when SIGNED_EN is 0, so the negation paths fold away.
  always_comb begin
    sgn_mode = (SIGNED_EN != 0) && is_signed;
    a_neg    = sgn_mode && dividend[WIDTH-1];
    b_neg    = sgn_mode && divisor[WIDTH-1];
    a_mag    = a_neg ? -dividend : dividend;
    b_mag    = b_neg ? -divisor : divisor;
    q_fix    = ((SIGNED_EN != 0) && q_neg) ? -q_q : q_q;
    r_fix    = ((SIGNED_EN != 0) && r_neg) ? -r_q : r_q;
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .r    (r_q),
    .q    (q_q),
    .d    (d_mag),
    .r_nxt(r_nxt),
    .q_nxt(q_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      valid       <= 1'b0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      d_mag       <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          valid <= 1'b0;
          // busy still high here means this is the valid cycle
          if (start && !busy) begin
            busy  <= 1'b1;
            cnt   <= '0;
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
            if (divisor == '0) begin
              quot        <= '1;
              rem         <= dividend;
              div_by_zero <= 1'b1;
              state       <= S_DONE;
            end else begin
              r_q   <= '0;
              q_q   <= a_mag;
              d_mag <= b_mag;
              state <= S_RUN;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        S_RUN: begin
          r_q <= r_nxt;
          q_q <= q_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          quot        <= q_fix;
          rem         <= r_fix;
          div_by_zero <= 1'b0;
          state       <= S_DONE;
        end
        S_DONE: begin
          valid <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider at WIDTH=8.
// Drives at negedge, samples at negedge.
module tb_seq_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic       is_signed;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       valid;
  logic [7:0] quot;
  logic [7:0] rem;
  logic       div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  int pulses;

  seq_divider #(
    .WIDTH    (8),
    .SIGNED_EN(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .valid      (valid),
    .quot       (quot),
    .rem        (rem),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one operation; returns the edge count at which valid was seen.
  // rp re-pulses start with other operands before edges 3 and 5.
  task automatic run_op(input logic sg, input logic [7:0] a,
                        input logic [7:0] b, input logic rp,
                        output int n);
    @(negedge clk);
    start     = 1'b1;
    is_signed = sg;
    dividend  = a;
    divisor   = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    n = 0;
    while (valid !== 1'b1 && n < 40) begin
      start = rp && (n == 2 || n == 4);
      if (start) begin
        dividend = 8'd50;
        divisor  = 8'd3;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_quot", 32'(quot), 32'd0);
    chk("rst_rem", 32'(rem), 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);
    rst = 1'b1;

    run_op(1'b0, 8'd200, 8'd7, 1'b0, lat);
    chk("u200_7_lat", 32'(lat), 32'd10);
    chk("u200_7_busy", 32'(busy), 32'd1);
    chk("u200_7_q", 32'(quot), 32'd28);
    chk("u200_7_r", 32'(rem), 32'd4);
    chk("u200_7_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    chk("u200_7_vend", 32'(valid), 32'd0);
    chk("u200_7_bend", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("hold_q", 32'(quot), 32'd28);
    chk("hold_r", 32'(rem), 32'd4);

    run_op(1'b1, 8'hF9, 8'd2, 1'b0, lat);
    chk("sm7_2_q", 32'(quot), 32'hFD);
    chk("sm7_2_r", 32'(rem), 32'hFF);

    run_op(1'b1, 8'd7, 8'hFE, 1'b0, lat);
    chk("s7_m2_q", 32'(quot), 32'hFD);
    chk("s7_m2_r", 32'(rem), 32'h01);

    run_op(1'b1, 8'hF9, 8'hFE, 1'b0, lat);
    chk("sm7_m2_q", 32'(quot), 32'h03);
    chk("sm7_m2_r", 32'(rem), 32'hFF);

    run_op(1'b0, 8'hF9, 8'd2, 1'b0, lat);
    chk("u249_2_q", 32'(quot), 32'h7C);
    chk("u249_2_r", 32'(rem), 32'h01);

    run_op(1'b1, 8'h80, 8'hFF, 1'b0, lat);
    chk("ovf_lat", 32'(lat), 32'd10);
    chk("ovf_q", 32'(quot), 32'h80);
    chk("ovf_r", 32'(rem), 32'h00);
    chk("ovf_dz", 32'(div_by_zero), 32'd0);

    run_op(1'b1, 8'h5A, 8'h00, 1'b0, lat);
    chk("dz_lat", 32'(lat), 32'd1);
    chk("dz_q", 32'(quot), 32'hFF);
    chk("dz_r", 32'(rem), 32'h5A);
    chk("dz_flag", 32'(div_by_zero), 32'd1);
    @(negedge clk);
    chk("dz_bend", 32'(busy), 32'd0);

    run_op(1'b0, 8'd100, 8'd9, 1'b1, lat);
    chk("rp_lat", 32'(lat), 32'd10);
    chk("rp_q", 32'(quot), 32'd11);
    chk("rp_r", 32'(rem), 32'd1);
    chk("rp_dz", 32'(div_by_zero), 32'd0);
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (valid === 1'b1) pulses++;
    end
    chk("rp_extra_valid", 32'(pulses), 32'd0);

    @(negedge clk);
    start     = 1'b1;
    is_signed = 1'b0;
    dividend  = 8'd77;
    divisor   = 8'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_quot", 32'(quot), 32'd0);
    chk("mid_rst_rem", 32'(rem), 32'd0);
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (valid === 1'b1) pulses++;
    end
    rst = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (valid === 1'b1) pulses++;
    end
    chk("mid_rst_stale", 32'(pulses), 32'd0);

    run_op(1'b0, 8'd15, 8'd4, 1'b0, lat);
    chk("post_rst_lat", 32'(lat), 32'd10);
    chk("post_rst_q", 32'(quot), 32'd3);
    chk("post_rst_r", 32'(rem), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
